lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter TSU_CYC, default 2, cycles RS/DATA held stable before EN rises.
REQ-002 Parameter TEN_CYC, default 12, cycles EN held high.
REQ-003 Parameter THD_CYC, default 2, cycles RS/DATA held stable after EN falls.
REQ-004 Parameter TCMD_CYC, default 2000, post-command wait cycles for normal commands and data.
REQ-005 Parameter TCLR_CYC, default 82000, post-command wait cycles for clear/home (RS=0, DATA 0x01, 0x02 or 0x03).
REQ-006 Parameter TPWR_CYC, default 750000, power-up wait cycles before the init sequence.
REQ-007 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-008 i_rstn  in  1  reset, synchronous, active-low.
REQ-009 i_req_vld  in  1  request valid from the processor IO side.
REQ-010 i_req_rs  in  1  register select of request (0 command, 1 data).
REQ-011 i_req_data  in  8  byte to write to the LCD.
REQ-012 o_req_rdy  out  1  request FIFO can accept; transfer when i_req_vld and o_req_rdy are both high at an edge.
REQ-013 o_busy  out  1  high when FSM is not IDLE or FIFO is not empty.
REQ-014 o_init_done  out  1  power-up init sequence complete.
REQ-015 o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw  out  1 each  LCD power, enable, register select, read/write.
REQ-016 o_lcd_data  out  8  LCD data bus.

Function
REQ-017 Request FIFO SHALL be 4 entries {rs,data}, in-order; o_req_rdy = not full, independent of pop in the same cycle.
REQ-018 FSM states SHALL be PWR, IDLE, SETUP, EN_HI, HOLD, WAIT.
REQ-019 PWR SHALL count TPWR_CYC cycles, then issue init commands 0x38, 0x0C, 0x01, 0x06 (RS=0) in order through SETUP/EN_HI/HOLD/WAIT.
REQ-020 FIFO SHALL accept requests during PWR and init but SHALL NOT drain until o_init_done=1.
REQ-021 o_init_done SHALL rise on the edge the FSM enters IDLE after the 0x06 wait and stay high until reset.
REQ-022 In IDLE with o_init_done=1 and FIFO non-empty, the FSM SHALL pop the head and enter SETUP on the same edge, registering o_lcd_rs/o_lcd_data.
REQ-023 SETUP lasts TSU_CYC cycles, EN_HI TEN_CYC cycles (o_lcd_en=1), HOLD THD_CYC cycles (o_lcd_en=0), all registered outputs.
REQ-024 Request accepted at edge k into an empty FIFO while idle SHALL give o_lcd_en rising at edge k+1+TSU_CYC.
REQ-025 o_lcd_rs/o_lcd_data SHALL NOT change from SETUP entry until HOLD exit.
REQ-026 WAIT SHALL last TCLR_CYC for RS=0 with DATA 0x01..0x03, else TCMD_CYC, then go to IDLE (or next init command).
REQ-027 o_lcd_rw SHALL be 0 always (write-only); o_lcd_on SHALL be 1 in every cycle after reset release.
REQ-028 All wait counters SHALL be 20 bits minimum and SHALL be sized from the largest parameter; each count is exact, no off-by-one.

Reset
REQ-029 With i_rstn=0 at an edge: state=PWR, counters=0, FIFO empty, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0, o_init_done=0, o_busy=1, o_req_rdy=1.
REQ-030 Reset mid-transfer (including EN_HI) SHALL drop o_lcd_en at that edge, discard FIFO contents and restart power-up.

Verification (TSU=1, TEN=3, THD=1, TCMD=5, TCLR=20, TPWR=10)
REQ-031 Release reset, no requests -> 10 idle cycles, then EN pulses of 3 cycles with DATA 0x38, 0x0C, 0x01, 0x06 (RS=0); the gap after 0x01 reflects 20-cycle WAIT; o_init_done rises after the final 5-cycle WAIT.
REQ-032 After init, push RS=1 0x41 at edge k -> o_lcd_en high at edges k+2..k+4; RS=1/DATA=0x41 stable k+1..k+5; o_busy low after WAIT.
REQ-033 During PWR hold i_req_vld with 5 distinct bytes -> 4 accepted, o_req_rdy low; 5th accepted after first pop; all 5 emitted in order.
REQ-034 After init, push 0x01 RS=0 then 0x41 RS=1 -> EN gap (0x01 fall to 0x41 rise) = THD + TCLR + 1 + TSU cycles.
REQ-035 Assert i_rstn=0 during EN_HI -> next edge o_lcd_en=0, o_init_done=0, o_req_rdy=1, FIFO empty; after release the init sequence repeats exactly as REQ-031.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: 4-deep request FIFO, power-up init
// sequence, and a SETUP/EN_HI/HOLD/WAIT timing engine with exact cycle counts.
module lcd_ctrl #(
    parameter int TSU_CYC  = 2,
    parameter int TEN_CYC  = 12,
    parameter int THD_CYC  = 2,
    parameter int TCMD_CYC = 2000,
    parameter int TCLR_CYC = 82000,
    parameter int TPWR_CYC = 750000
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int MAX_A = (TSU_CYC > TEN_CYC) ? TSU_CYC : TEN_CYC;
    localparam int MAX_B = (THD_CYC > TCMD_CYC) ? THD_CYC : TCMD_CYC;
    localparam int MAX_C = (TCLR_CYC > TPWR_CYC) ? TCLR_CYC : TPWR_CYC;
    localparam int MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W = ($clog2(MAX_P + 1) > 20) ? $clog2(MAX_P + 1) : 20;

    typedef enum logic [2:0] {
        S_PWR,
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               init_done_q, init_done_d;
    logic               en_q, en_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               on_q, on_d;
    logic [3:0][8:0]    mem_q, mem_d;
    logic [1:0]         wr_ptr_q, wr_ptr_d;
    logic [1:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [8:0]         head;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear display / return home need the long post-command wait.
    function automatic logic is_clear(input logic rs, input logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    function automatic logic at_last(input logic [CNT_W-1:0] c, input int len);
        return c == CNT_W'(len - 1);
    endfunction

    assign fifo_full  = (count_q == 3'd4);
    assign fifo_empty = (count_q == 3'd0);
    assign push       = i_req_vld && !fifo_full;
    assign pop        = (state_q == S_IDLE) && init_done_q && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {i_req_rs, i_req_data};
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        init_done_d = init_done_q;
        en_d        = en_q;
        rs_d        = rs_q;
        data_d      = data_q;
        on_d        = 1'b1;
        case (state_q)
            S_PWR: begin
                if (at_last(cnt_q, TPWR_CYC)) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (pop) begin
                    state_d = S_SETUP;
                    rs_d    = head[8];
                    data_d  = head[7:0];
                end
            end
            S_SETUP: begin
                if (at_last(cnt_q, TSU_CYC)) begin
                    state_d = S_EN_HI;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end
            end
            S_EN_HI: begin
                if (at_last(cnt_q, TEN_CYC)) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (at_last(cnt_q, THD_CYC)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (at_last(cnt_q, is_clear(rs_q, data_q) ? TCLR_CYC : TCMD_CYC)) begin
                    cnt_d = '0;
                    // During init the next command goes straight to SETUP.
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else if (idx_q == 2'd3) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_cmd(idx_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = S_PWR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q     <= S_PWR;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            on_q        <= 1'b0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            on_q        <= on_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // FIFO storage carries no reset; the pointers alone define validity.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    assign o_req_rdy   = !fifo_full;
    assign o_busy      = (state_q != S_IDLE) || !fifo_empty;
    assign o_init_done = init_done_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: per-cycle expected-waveform table built from phase
// lengths, plus a hand-written FIFO-full sequence during power-up.
module tb_lcd_ctrl;

    localparam int TSU  = 1;
    localparam int TEN  = 3;
    localparam int THD  = 1;
    localparam int TCMD = 5;
    localparam int TCLR = 20;
    localparam int TPWR = 10;

    logic       clk = 1'b0;
    logic       rstn;
    logic       vld;
    logic       rs;
    logic [7:0] data;
    logic       o_req_rdy, o_busy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .TSU_CYC (TSU),
        .TEN_CYC (TEN),
        .THD_CYC (THD),
        .TCMD_CYC(TCMD),
        .TCLR_CYC(TCLR),
        .TPWR_CYC(TPWR)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_req_vld  (vld),
        .i_req_rs   (rs),
        .i_req_data (data),
        .o_req_rdy  (o_req_rdy),
        .o_busy     (o_busy),
        .o_init_done(o_init_done),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_data (o_lcd_data)
    );

    typedef struct {
        string      tag;
        logic       rstn;
        logic       vld;
        logic       rs;
        logic [7:0] d;
        logic       en;
        logic       ers;
        logic [7:0] ed;
        logic       on;
        logic       rdy;
        logic       busy;
        logic       init;
    } vec_t;

    vec_t       vecs[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    logic       cur_rs;
    logic [7:0] cur_d;
    logic       cur_init;

    task automatic add(input string tag, input logic rn, input logic v, input logic r,
                       input logic [7:0] d, input logic en, input logic rdy, input logic busy);
        vec_t t;
        t.tag = tag; t.rstn = rn; t.vld = v; t.rs = r; t.d = d;
        t.en = en; t.ers = cur_rs; t.ed = cur_d; t.on = rn;
        t.rdy = rdy; t.busy = busy; t.init = cur_init;
        vecs.push_back(t);
    endtask

    task automatic add_reset(input string tag);
        cur_rs = 1'b0; cur_d = 8'h00; cur_init = 1'b0;
        add(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic add_phase(input string tag, input int n, input logic en);
        for (int i = 0; i < n; i++) add(tag, 1'b1, 1'b0, 1'b0, 8'h00, en, 1'b1, 1'b1);
    endtask

    task automatic add_xfer(input string tag, input logic r, input logic [7:0] d, input int w);
        cur_rs = r; cur_d = d;
        add_phase({tag, "_su"}, TSU, 1'b0);
        add_phase({tag, "_en"}, TEN, 1'b1);
        add_phase({tag, "_hd"}, THD, 1'b0);
        add_phase({tag, "_wt"}, w, 1'b0);
    endtask

    // The reset sample itself is the first power-up cycle.
    task automatic add_init();
        add_phase("pwr", TPWR - 1, 1'b0);
        add_xfer("i38", 1'b0, 8'h38, TCMD);
        add_xfer("i0c", 1'b0, 8'h0C, TCMD);
        add_xfer("i01", 1'b0, 8'h01, TCLR);
        add_xfer("i06", 1'b0, 8'h06, TCMD);
        cur_init = 1'b1;
    endtask

    task automatic add_idle(input string tag, input int n, input logic busy);
        for (int i = 0; i < n; i++) add(tag, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, busy);
    endtask

    task automatic add_push(input string tag, input logic r, input logic [7:0] d);
        add(tag, 1'b1, 1'b1, r, d, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic patch_push(input int idx, input logic r, input logic [7:0] d);
        vec_t t;
        t = vecs[idx];
        t.vld = 1'b1; t.rs = r; t.d = d;
        vecs[idx] = t;
    endtask

    task automatic check(input string name, input logic ok, input string got, input string want);
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [5];
        logic [14:0] got, want;
        logic [7:0] cap_d[$];
        logic       cap_r[$];
        logic [7:0] exp_d [9];
        logic       exp_r [9];
        logic       prev_en, seen_init, took, done;
        int         acc, p;
        vec_t       t;

        rstn = 1'b0; vld = 1'b0; rs = 1'b0; data = 8'h00;

        // Power-up and init sequence.
        add_reset("rst0");
        add_reset("rst1");
        add_init();
        add_idle("post_init", 3, 1'b0);

        // Single data write.
        add_push("push41", 1'b1, 8'h41);
        add_xfer("d41", 1'b1, 8'h41, TCMD);
        add_idle("idle41", 2, 1'b0);

        // Clear followed by data: long wait, then IDLE, then next SETUP.
        add_push("push01", 1'b0, 8'h01);
        p = vecs.size();
        add_xfer("c01", 1'b0, 8'h01, TCLR);
        patch_push(p, 1'b1, 8'h41);
        add_idle("gap", 1, 1'b1);
        add_xfer("d41b", 1'b1, 8'h41, TCMD);
        add_idle("idle41b", 2, 1'b0);

        // Reset during EN_HI with a second request still queued.
        add_push("push55", 1'b1, 8'h55);
        p = vecs.size();
        cur_rs = 1'b1; cur_d = 8'h55;
        add_phase("d55_su", TSU, 1'b0);
        add_phase("d55_en", 2, 1'b1);
        patch_push(p, 1'b1, 8'h66);
        add_reset("rst_en");
        add_init();
        add_idle("post_reinit", 4, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            rstn = t.rstn; vld = t.vld; rs = t.rs; data = t.d;
            @(posedge clk);
            #1;
            got  = {o_lcd_en, o_lcd_rs, o_lcd_data, o_lcd_on, o_lcd_rw, o_req_rdy, o_busy, o_init_done};
            want = {t.en, t.ers, t.ed, t.on, 1'b0, t.rdy, t.busy, t.init};
            check($sformatf("vec[%0d] %s", i, t.tag), got === want,
                  $sformatf("en=%b rs=%b data=%h on=%b rw=%b rdy=%b busy=%b init=%b",
                            got[14], got[13], got[12:5], got[4], got[3], got[2], got[1], got[0]),
                  $sformatf("en=%b rs=%b data=%h on=%b rw=%b rdy=%b busy=%b init=%b",
                            want[14], want[13], want[12:5], want[4], want[3], want[2], want[1], want[0]));
        end

        // FIFO fills during power-up; fifth byte waits for the first pop.
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4; bytes[4] = 8'hE5;
        exp_d[0] = 8'h38; exp_d[1] = 8'h0C; exp_d[2] = 8'h01; exp_d[3] = 8'h06;
        for (int i = 0; i < 4; i++) exp_r[i] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_d[4 + i] = bytes[i];
            exp_r[4 + i] = 1'b1;
        end
        rstn = 1'b0; vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1; vld = 1'b1; rs = 1'b1; data = bytes[0];
        acc = 0; prev_en = 1'b0; seen_init = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            took = vld && o_req_rdy;
            @(posedge clk);
            #1;
            if (took) begin
                acc++;
                if (acc < 5) data = bytes[acc];
                else vld = 1'b0;
            end
            if (cyc == 3)
                check("fifo_full_after_4", acc == 4 && o_req_rdy == 1'b0,
                      $sformatf("accepted=%0d rdy=%b", acc, o_req_rdy), "accepted=4 rdy=0");
            if (o_init_done && !seen_init) begin
                seen_init = 1'b1;
                check("no_drain_before_init", acc == 4 && o_req_rdy == 1'b0,
                      $sformatf("accepted=%0d rdy=%b", acc, o_req_rdy), "accepted=4 rdy=0");
            end
            if (o_lcd_en && !prev_en) begin
                cap_d.push_back(o_lcd_data);
                cap_r.push_back(o_lcd_rs);
            end
            prev_en = o_lcd_en;
            if (cap_d.size() == 9 && !o_busy) done = 1'b1;
        end
        check("fifo_seq_complete", done && acc == 5,
              $sformatf("pulses=%0d accepted=%0d", cap_d.size(), acc), "pulses=9 accepted=5");
        for (int i = 0; i < 9; i++) begin
            if (i < cap_d.size())
                check($sformatf("fifo_order[%0d]", i), cap_d[i] == exp_d[i] && cap_r[i] == exp_r[i],
                      $sformatf("rs=%b data=%h", cap_r[i], cap_d[i]),
                      $sformatf("rs=%b data=%h", exp_r[i], exp_d[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
